// File: rtl/hilo_accumulate_unit_pkg.sv
// Shared definitions for the HI/LO accumulate unit: widths, op encoding and
// the helper that decides which ops occupy the commit pipeline.
package hilo_accumulate_unit_pkg;

    localparam int unsigned DW   = 32;
    localparam int unsigned PW   = 2 * DW;
    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_MADD = 3'd2,
        OP_MSUB = 3'd3,
        OP_MTHI = 3'd4,
        OP_MTLO = 3'd5
    } hilo_op_e;

    // Encodings 6 and 7 are treated as NOP and never enter stage 1.
    function automatic logic is_cmd(input logic [OP_W-1:0] op);
        return (op != 3'd0) && (op <= 3'd5);
    endfunction

endpackage

// File: rtl/hilo_accumulate_unit_if.sv
// Command/read bundle between the EX stage and the HI/LO accumulate unit.
interface hilo_accumulate_unit_if;
    import hilo_accumulate_unit_pkg::*;

    logic            Valid;
    logic [OP_W-1:0] Op;
    logic [PW-1:0]   ProductIn;
    logic [DW-1:0]   RsIn;
    logic            Flush;
    logic            ReadSel;
    logic [DW-1:0]   ReadData;
    logic            Busy;
    logic            AccOvf;

    modport master (
        output Valid, Op, ProductIn, RsIn, Flush, ReadSel,
        input  ReadData, Busy, AccOvf
    );

    modport slave (
        input  Valid, Op, ProductIn, RsIn, Flush, ReadSel,
        output ReadData, Busy, AccOvf
    );

endinterface

// File: rtl/hilo_accumulate_unit_add64.sv
// 64-bit add/subtract with signed overflow, used by the MADD/MSUB commit path.
module hilo_add64
    import hilo_accumulate_unit_pkg::*;
(
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] b,
    input  logic          sub,
    output logic [PW-1:0] sum,
    output logic          ovf
);

    logic [PW-1:0] b_eff;

    // Overflow is judged against the negated operand for subtraction.
    always_comb begin
        b_eff = sub ? (~b + PW'(1)) : b;
        sum   = a + b_eff;
        ovf   = (a[PW-1] == b_eff[PW-1]) && (sum[PW-1] != a[PW-1]);
    end

endmodule

// File: rtl/hilo_accumulate_unit.sv
// HI/LO register pair with a one-entry capture stage feeding the commit stage;
// Busy flags the cycle in which a captured command has not yet committed.
module hilo_accumulate_unit
    import hilo_accumulate_unit_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Reset,
    hilo_accumulate_unit_if.slave  bus
);

    logic          s1_valid;
    hilo_op_e      s1_op;
    logic [PW-1:0] s1_prod;
    logic [DW-1:0] s1_rs;

    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
    logic          acc_ovf;

    logic          capture;
    logic [PW-1:0] add_sum;
    logic          add_ovf;

    assign capture = bus.Valid && !bus.Flush && is_cmd(bus.Op);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_prod  <= '0;
            s1_rs    <= '0;
        end else begin
            s1_valid <= capture;
            if (capture) begin
                s1_op   <= hilo_op_e'(bus.Op);
                s1_prod <= bus.ProductIn;
                s1_rs   <= bus.RsIn;
            end
        end
    end

    hilo_add64 u_add (
        .a   ({hi, lo}),
        .b   (s1_prod),
        .sub (s1_op == OP_MSUB),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // A Flush only gates capture; whatever already sits in stage 1 commits.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi      <= '0;
            lo      <= '0;
            acc_ovf <= 1'b0;
        end else if (s1_valid) begin
            case (s1_op)
                OP_MULT: begin
                    {hi, lo} <= s1_prod;
                    acc_ovf  <= 1'b0;
                end
                OP_MADD, OP_MSUB: begin
                    {hi, lo} <= add_sum;
                    acc_ovf  <= acc_ovf | add_ovf;
                end
                OP_MTHI: begin
                    hi      <= s1_rs;
                    acc_ovf <= 1'b0;
                end
                OP_MTLO: begin
                    lo      <= s1_rs;
                    acc_ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ReadData = bus.ReadSel ? hi : lo;
    assign bus.Busy     = s1_valid;
    assign bus.AccOvf   = acc_ovf;

endmodule

// File: tb/tb_hilo_accumulate_unit.sv
// Directed and randomized checks of hilo_accumulate_unit against a
// value-level model of the HI/LO pair and its one-cycle commit delay.
module tb_hilo_accumulate_unit;
    import hilo_accumulate_unit_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    hilo_accumulate_unit_if bus();

    hilo_accumulate_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model: 64-bit accumulator value plus the command still waiting to land.
    logic [63:0] m_acc;
    logic        m_ovf;
    logic        m_pend;
    logic [2:0]  m_op;
    logic [63:0] m_p;
    logic [31:0] m_rs;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = '0;
        m_ovf  = 1'b0;
        m_pend = 1'b0;
        m_op   = '0;
        m_p    = '0;
        m_rs   = '0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] op, input logic [63:0] p,
                              input logic [31:0] rs, input logic fl);
        logic [63:0]        operand;
        logic signed [64:0] wide;
        if (m_pend) begin
            case (m_op)
                3'd1: begin m_acc = m_p; m_ovf = 1'b0; end
                3'd2, 3'd3: begin
                    operand = (m_op == 3'd3) ? -m_p : m_p;
                    wide = $signed({m_acc[63], m_acc}) + $signed({operand[63], operand});
                    if (wide[64] != wide[63]) m_ovf = 1'b1;
                    m_acc = wide[63:0];
                end
                3'd4: begin m_acc[63:32] = m_rs; m_ovf = 1'b0; end
                3'd5: begin m_acc[31:0]  = m_rs; m_ovf = 1'b0; end
                default: ;
            endcase
        end
        m_pend = v && !fl && (op >= 3'd1) && (op <= 3'd5);
        if (m_pend) begin
            m_op = op;
            m_p  = p;
            m_rs = rs;
        end
    endtask

    task automatic check_all(input string tag);
        bus.ReadSel = 1'b0;
        #1 check_eq({tag, ".lo"}, 64'(bus.ReadData), 64'(m_acc[31:0]));
        bus.ReadSel = 1'b1;
        #1 check_eq({tag, ".hi"}, 64'(bus.ReadData), 64'(m_acc[63:32]));
        check_eq({tag, ".busy"}, 64'(bus.Busy), 64'(m_pend));
        check_eq({tag, ".ovf"}, 64'(bus.AccOvf), 64'(m_ovf));
    endtask

    task automatic cycle(input logic v, input logic [2:0] op, input logic [63:0] p,
                         input logic [31:0] rs, input logic fl, input string tag);
        bus.Valid     = v;
        bus.Op        = op;
        bus.ProductIn = p;
        bus.RsIn      = rs;
        bus.Flush     = fl;
        @(posedge Clk);
        model_edge(v, op, p, rs, fl);
        #1;
        bus.Valid = 1'b0;
        bus.Flush = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 3'd0, '0, '0, 1'b0, tag);
    endtask

    initial begin
        logic [63:0] rp;
        logic [2:0]  rop;
        logic        rv, rf;

        bus.Valid = 1'b0; bus.Op = '0; bus.ProductIn = '0;
        bus.RsIn = '0; bus.Flush = 1'b0; bus.ReadSel = 1'b0;
        model_reset();
        #2 check_all("rst_init");
        #8 Reset = 1'b1;

        // Async reset while an MTHI is committed and another sits in stage 1
        cycle(1'b1, 3'd4, '0, 32'hDEAD, 1'b0, "mthi_dead");
        idle("mthi_dead_commit");
        check_eq("mthi_dead_val", 64'(bus.ReadData), 64'h0000_DEAD);
        cycle(1'b1, 3'd4, '0, 32'hBEEF, 1'b0, "mthi_beef");
        Reset = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        #2 Reset = 1'b1;
        idle("post_rst");

        // MULT of -6
        cycle(1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFA, '0, 1'b0, "mult_neg6");
        idle("mult_neg6_commit");
        check_eq("mult_neg6_hi", 64'(dut.hi), 64'hFFFF_FFFF);
        check_eq("mult_neg6_lo", 64'(dut.lo), 64'hFFFF_FFFA);

        // MULT 10, MADD 5, MSUB 3 back to back -> 12
        cycle(1'b1, 3'd1, 64'd10, '0, 1'b0, "chain_mult");
        cycle(1'b1, 3'd2, 64'd5,  '0, 1'b0, "chain_madd");
        cycle(1'b1, 3'd3, 64'd3,  '0, 1'b0, "chain_msub");
        idle("chain_done");
        check_eq("chain_acc", {dut.hi, dut.lo}, 64'd12);

        // Positive overflow, then MTLO clears the sticky flag
        cycle(1'b1, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 1'b0, "ovf_mult");
        cycle(1'b1, 3'd2, 64'd1, '0, 1'b0, "ovf_madd");
        idle("ovf_done");
        check_eq("ovf_flag", 64'(bus.AccOvf), 64'd1);
        cycle(1'b1, 3'd5, '0, 32'd7, 1'b0, "mtlo7");
        idle("mtlo7_done");
        check_eq("mtlo7_acc", {dut.hi, dut.lo}, 64'h8000_0000_0000_0007);

        // Flush blocks its own capture but not the entry already in stage 1
        cycle(1'b1, 3'd4, '0, 32'h1234, 1'b1, "flush_mthi");
        cycle(1'b1, 3'd5, '0, 32'd9, 1'b0, "mtlo9");
        cycle(1'b1, 3'd1, 64'h1111_2222_3333_4444, '0, 1'b1, "flush_behind_mtlo9");
        idle("mtlo9_done");

        // Reserved ops, then a read during Busy
        cycle(1'b1, 3'd6, 64'hFFFF, 32'hFFFF, 1'b0, "op6");
        cycle(1'b1, 3'd7, 64'hFFFF, 32'hFFFF, 1'b0, "op7");
        cycle(1'b1, 3'd1, 64'hAAAA_BBBB_0000_0001, '0, 1'b0, "mult_busy_read");
        idle("mult_busy_read_done");

        // Overflow via MSUB of a large negative from a positive accumulator
        cycle(1'b1, 3'd1, 64'h7000_0000_0000_0000, '0, 1'b0, "msub_ovf_mult");
        cycle(1'b1, 3'd3, 64'h9000_0000_0000_0000, '0, 1'b0, "msub_ovf");
        idle("msub_ovf_done");

        for (int unsigned i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 9) < 8);
            rf  = ($urandom_range(0, 9) < 1);
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: rp = 64'h7FFF_FFFF_FFFF_FFFF;
                1: rp = 64'h8000_0000_0000_0000;
                2: rp = 64'(32'($urandom_range(0, 100)));
                default: rp = {$urandom, $urandom};
            endcase
            cycle(rv, rop, rp, $urandom, rf, $sformatf("rand%0d", i));
        end
        idle("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
